// File: rtl/pipeline_stage_elastic_if.sv
// rtl/pipeline_stage_elastic_if.sv - valid/ready stage-boundary bundle for pipeline_stage_elastic
// Purpose: carries one pipeline entry (result, destination, write-enable, opcode) with a
//          valid/ready handshake between two pipeline stages.
// Signals: valid      producer -> consumer  entry valid
//          ready      consumer -> producer  consumer accepts entry
//          alu_result producer -> consumer  result payload (DATA_W)
//          rd         producer -> consumer  destination register (RD_W)
//          regwrite   producer -> consumer  register write enable
//          op         producer -> consumer  opcode (OP_W)
// Modports: master = producer side, slave = consumer side.
interface pipeline_stage_elastic_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int OP_W   = 7
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] alu_result;
  logic [RD_W-1:0]   rd;
  logic              regwrite;
  logic [OP_W-1:0]   op;

  modport master (output valid, alu_result, rd, regwrite, op, input ready);
  modport slave  (input valid, alu_result, rd, regwrite, op, output ready);
endinterface

// File: rtl/pipeline_stage_elastic.sv
// rtl/pipeline_stage_elastic.sv - elastic pipeline register with flush and optional skid buffer
// Purpose: registers one pipeline entry per cycle between two stages (e.g. EX->MEM).
//          SKID=1: two entries (main + skid), in_ready is registered state only.
//          SKID=0: one entry, in_ready = !out_valid | out_ready.
// Ports:   clk     clock, rising edge
//          reset   synchronous, active-low
//          flush   discard held entries and the entry offered this cycle
//          in_if   slave side of the upstream handshake (in_if.ready is our in_ready)
//          out_if  master side of the downstream handshake; out_if.regwrite is gated
//                  by out_valid so a stale write never reaches the register file
module pipeline_stage_elastic #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int OP_W   = 7,
  parameter int SKID   = 1
) (
  input logic                      clk,
  input logic                      reset,
  input logic                      flush,
  pipeline_stage_elastic_if.slave  in_if,
  pipeline_stage_elastic_if.master out_if
);

  localparam int PW = DATA_W + RD_W + 1 + OP_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic [PW-1:0] in_payload;
  logic          main_regwrite;
  logic          in_ready_c;
  logic          out_valid_c;
  logic          accept;
  logic          issue;
  logic          load_main_in;
  logic          load_main_skid;
  logic          load_skid;

  assign in_payload = {in_if.alu_result, in_if.rd, in_if.regwrite, in_if.op};

  always_comb begin
    state_d        = state_q;
    in_ready_c     = 1'b0;
    out_valid_c    = 1'b0;
    accept         = 1'b0;
    issue          = 1'b0;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    unique case (state_q)
      S_EMPTY: begin
        in_ready_c  = 1'b1;
        out_valid_c = 1'b0;
      end
      S_BUSY: begin
        // Without the skid register the only way to take a new entry while
        // holding one is to hand the held one downstream in the same cycle.
        in_ready_c  = (SKID != 0) ? 1'b1 : out_if.ready;
        out_valid_c = 1'b1;
      end
      S_FULL: begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b1;
      end
      default: begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
      end
    endcase

    // in_ready must read 0 for as long as reset is held low.
    if (!reset) begin
      in_ready_c = 1'b0;
    end

    accept = in_if.valid & in_ready_c & ~flush;
    issue  = out_valid_c & out_if.ready;

    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        if (accept && issue) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          // Only reachable with SKID!=0: in_ready is 0 here otherwise.
          load_skid = 1'b1;
          state_d   = S_FULL;
        end else if (issue) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (issue) begin
          load_main_skid = 1'b1;
          state_d        = S_BUSY;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase

    // Flush empties the stage. Register loads are suppressed so the data
    // outputs keep their last value while out_valid is low.
    if (flush) begin
      state_d        = S_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_q <= in_payload;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_payload;
      end
    end
  end

  assign in_if.ready = in_ready_c;
  assign out_if.valid = out_valid_c;
  assign {out_if.alu_result, out_if.rd, main_regwrite, out_if.op} = main_q;
  assign out_if.regwrite = out_valid_c & main_regwrite;

endmodule
